instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch stage placed directly upstream of the decode stage.
- On `start`, it streams 32-bit instruction words from a program memory read port into a small prefetch FIFO.
- It presents one registered instruction at a time on `instr`, with a one-cycle `instr_valid`, throttled by the control unit's `ctrl_busy`.
- While nothing is being issued, `instr` carries a benign idle word, so the combinational decoder downstream asserts no write and no command.

Parameters:
- ADDR_W, 16, width of program memory word address / PC
- DEPTH, 4, prefetch FIFO depth in words (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high (1 = reset) despite the suffix
- start  in  1  one-cycle pulse; begin fetching at base_addr
- base_addr  in  ADDR_W  first program word address, sampled on start
- mem_rd_req  out  1  one-cycle read request pulse
- mem_rd_addr  out  ADDR_W  read address, valid with mem_rd_req
- mem_rd_valid  in  1  read data valid; any latency ≥1 cycle
- mem_rd_data  in  32  returned instruction word
- ctrl_busy  in  1  control unit is executing a command; hold issue
- instr  out  32  instruction to decode; IDLE_INSTR when not issuing
- instr_valid  out  1  one-cycle pulse with each issued instruction
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the halt instruction issues
- err  out  1  one-cycle pulse when a reserved-opcode word is dropped

Behaviour:
- Reset values:
  - `mem_rd_req`, `instr_valid`, `busy`, `done`, `err` = 0
  - `mem_rd_addr` = 0
  - `instr` = IDLE_INSTR = 32'h6000_0000 (opcode 110: no write, no command)
  - FIFO empty; `outstanding` = 0; `halt_seen` = 0; FSM in IDLE
- Instruction format:
  - bit31 = HALT (last instruction of the program)
  - bits30:28 = opcode
  - opcode 011 is reserved
- FSM: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: `start` loads `pc` = `base_addr`, sets `busy`, clears `halt_seen`, goes to RUN. `start` is ignored in every other state.
  - RUN, request rule: issue `mem_rd_req` (with `mem_rd_addr` = `pc`) when all of these hold:
    - `outstanding` = 0
    - `halt_seen` = 0
    - FIFO count + `outstanding` < DEPTH
  - RUN, request side effects: the request sets `outstanding`. At most one read is in flight.
  - RUN, response: `mem_rd_valid` with `outstanding` = 1 pushes `mem_rd_data`, clears `outstanding`, and increments `pc`. `pc` wraps from 2^ADDR_W−1 to 0. If `mem_rd_data[31]` = 1, set `halt_seen` and go to DRAIN.
  - `mem_rd_valid` while `outstanding` = 0 is ignored (no push).
  - DRAIN: no new requests. Issue continues until the FIFO is empty and the HALT word has issued; then pulse `done` for one cycle, clear `busy`, go to IDLE.
- Issue rule, evaluated each cycle in RUN or DRAIN: pop the FIFO head when all of these hold:
  - FIFO is not empty
  - `ctrl_busy` = 0
  - `instr_valid` was 0 in the previous cycle (one-cycle gap so the control unit can raise `ctrl_busy`)
- Issue outcome: on the next edge `instr` ← head and `instr_valid` = 1 for exactly one cycle. In every other cycle `instr` ← IDLE_INSTR.
- Reserved opcode: a popped head with opcode 011 is not issued. `instr` stays IDLE_INSTR and `err` pulses in the same cycle `instr_valid` would have. If that word also carries HALT, `done` still follows one cycle later.
- Latency:
  - `start` at cycle 0 -> `mem_rd_req` at cycle 1
  - `mem_rd_valid` at cycle k (FIFO empty, `ctrl_busy` = 0) -> `instr_valid` at cycle k+2: push at edge k, pop at edge k+1
- Simultaneous push and pop in the same cycle is legal; count is unchanged.
- Full FIFO: no request is issued. Reads never overflow, by the request rule.
- Reset mid-operation clears all state. A read response arriving after reset is discarded because `outstanding` = 0.

Decomposition:
- Shared package `ctrl_pkg` holds:
  - opcode constants: OP_PROC = 3'b000, OP_RDN_LOAD = 3'b100, OP_DNN_LOAD = 3'b101, OP_RSVD = 3'b011, OP_IDLE = 3'b110
  - IDLE_INSTR
  - HALT_BIT = 31
  - fetch state enum {IDLE, RUN, DRAIN}
- One sub-module, `instr_fifo`:
  - synchronous DEPTH×32 FIFO with push/pop and full/empty/count
  - asynchronous active-high reset
  - simultaneous push+pop supported

Test Plan:
- Single-word program: base_addr 0x0010, memory[0x10] = 32'h8000_0000 (HALT, opcode 000), read latency 2, start -> mem_rd_req with addr 0x0010 at cycle 1; instr_valid once with instr 32'h8000_0000; done one cycle later; busy low after done.
- Stream and backpressure: 6 words at 0x0000–0x0005, last has HALT, ctrl_busy held high 20 cycles after first issue -> at most DEPTH words buffered, no mem_rd_req while full; after release, all 6 words issued in order, each instr_valid separated by ≥1 idle cycle, instr = 32'h6000_0000 between them.
- PC wrap: base_addr 0xFFFF, words at 0xFFFF and 0x0000 (HALT) -> requests to 0xFFFF then 0x0000; both words issued.
- Reserved opcode: middle word 32'h3000_0001 -> err pulses once, that word never appears on instr, remaining words issue, done asserted.
- Reset mid-run: assert rst_n for 1 cycle while a read is outstanding, then return mem_rd_valid -> no push, instr_valid stays 0, outputs at reset values, start afterwards fetches from the new base_addr.
- Spurious mem_rd_valid in IDLE and start during RUN -> both ignored; FIFO count and pc unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the fetch/decode/control slice: instruction fields,
// opcode constants and the fetch FSM state type.
package ctrl_pkg;

  localparam int HALT_BIT = 31;

  localparam logic [2:0] OP_PROC     = 3'b000;
  localparam logic [2:0] OP_RDN_LOAD = 3'b100;
  localparam logic [2:0] OP_DNN_LOAD = 3'b101;
  localparam logic [2:0] OP_RSVD     = 3'b011;
  localparam logic [2:0] OP_IDLE     = 3'b110;

  // Opcode 110 with every other field zero: the decoder raises no write and no command.
  localparam logic [31:0] IDLE_INSTR = {1'b0, OP_IDLE, 28'h0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous prefetch FIFO with first-word-visible head output.
// Push and pop may occur in the same cycle, including when full.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers guarantee stale
  // entries are never read, and leaving it out keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: prefetches program words into a small FIFO and
// issues them one at a time to the decoder, idling on IDLE_INSTR otherwise.
module instr_fetch
  import ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  input  logic              ctrl_busy,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              outstanding;
  logic              halt_seen;
  logic              halt_issued;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              req_fire;
  logic              rsp_accept;
  logic              head_rsvd;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (fifo_push),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Words buffered plus the one read in flight must never exceed the FIFO.
  assign occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(outstanding);
  // Responses only count while a read is in flight; anything else is stale.
  assign rsp_accept = mem_rd_valid && outstanding;
  assign fifo_push  = rsp_accept;
  assign head_rsvd  = (fifo_head[30:28] == OP_RSVD);

  always_comb begin
    // NOTE: each output of this block gets a default first, so no path through
    // the conditions below can leave it unassigned and infer a latch.
    req_fire = 1'b0;
    fifo_pop = 1'b0;
    if (state == RUN) begin
      req_fire = !outstanding && !halt_seen && !fifo_full &&
                 (occupancy < (CNT_W+1)'(DEPTH));
    end
    // The gap after each issue gives the control unit a cycle to raise ctrl_busy.
    if (state == RUN || state == DRAIN) begin
      fifo_pop = !fifo_empty && !ctrl_busy && !instr_valid;
    end
  end

  assign mem_rd_req  = req_fire;
  assign mem_rd_addr = pc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= 1'b0;
      halt_seen   <= 1'b0;
      halt_issued <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr       <= IDLE_INSTR;
      instr_valid <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      instr       <= IDLE_INSTR;
      instr_valid <= 1'b0;

      // Reserved words are dropped silently on the instr bus and flagged on err.
      if (fifo_pop) begin
        if (head_rsvd) begin
          err <= 1'b1;
        end else begin
          instr       <= fifo_head;
          instr_valid <= 1'b1;
        end
        if (fifo_head[HALT_BIT]) halt_issued <= 1'b1;
      end

      if (req_fire) outstanding <= 1'b1;

      if (rsp_accept) begin
        outstanding <= 1'b0;
        pc          <= pc + ADDR_W'(1);
        if (mem_rd_data[HALT_BIT]) begin
          halt_seen <= 1'b1;
          state     <= DRAIN;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            pc          <= base_addr;
            busy        <= 1'b1;
            halt_seen   <= 1'b0;
            halt_issued <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
        end
        DRAIN: begin
          // The HALT word is the last one pushed, so the FIFO is empty once it has left.
          if (halt_issued && fifo_empty) begin
            done        <= 1'b1;
            busy        <= 1'b0;
            halt_issued <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
